// File: rtl/uart2bus_pkg.sv
// rtl/uart2bus_pkg.sv - shared ASCII constants, FSM state types and hex helper for uart2bus
package uart2bus_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_R_UP  = 8'h52;
  localparam logic [7:0] ASCII_R_LO  = 8'h72;
  localparam logic [7:0] ASCII_W_UP  = 8'h57;
  localparam logic [7:0] ASCII_W_LO  = 8'h77;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    SEND_LO,
    SEND_CR,
    SEND_LF
  } fmt_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with tx_start/tx_data/tx_done handshake
module uart_tx_byte
  import uart2bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       ser_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_t       state;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [7:0]       shift_data;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);
  // tx_done marks the last cycle of the stop bit so a new start can follow with no gap.
  assign tx_done = (state == S_STOP) && bit_end;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_idx    <= 3'd0;
      baud_cnt   <= '0;
      shift_data <= 8'h00;
      ser_out    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (tx_start) begin
            state      <= S_START;
            shift_data <= tx_data;
            ser_out    <= 1'b0;
          end
        end
        S_START: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= 3'd0;
            ser_out <= shift_data[0];
          end
        end
        S_DATA: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              ser_out <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              ser_out <= shift_data[bit_idx + 3'd1];
            end
          end
        end
        S_STOP: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
          if (bit_end) begin
            if (tx_start) begin
              state      <= S_START;
              shift_data <= tx_data;
              ser_out    <= 1'b0;
            end else begin
              state   <= S_IDLE;
              ser_out <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          ser_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_resp_tx.sv
// rtl/uart_resp_tx.sv - formats bus response bytes as hex text lines or raw bytes onto the UART
module uart_resp_tx
  import uart2bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  input  logic       bin_mode,
  output logic       rd_ready,
  output logic       ser_out,
  output logic       busy
);

  fmt_state_t state;
  fmt_state_t next_char;
  logic [7:0] data_q;
  logic       bin_q;
  logic       accept;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] tx_data;
  logic [7:0] src_byte;
  logic       src_bin;

  assign accept = rd_valid && rd_ready;
  assign busy   = ~rd_ready;

  // The first character is built straight from rd_data so its start bit leaves on the accept edge.
  always_comb begin
    next_char = state;
    tx_start  = 1'b0;
    src_byte  = data_q;
    src_bin   = bin_q;
    case (state)
      IDLE: begin
        tx_start  = accept;
        src_byte  = rd_data;
        src_bin   = bin_mode;
        next_char = bin_mode ? SEND_LO : SEND_HI;
      end
      SEND_HI: begin
        tx_start  = tx_done;
        next_char = SEND_LO;
      end
      SEND_LO: begin
        tx_start  = tx_done && !bin_q;
        next_char = bin_q ? IDLE : SEND_CR;
      end
      SEND_CR: begin
        tx_start  = tx_done;
        next_char = SEND_LF;
      end
      default: begin
        next_char = IDLE;
      end
    endcase

    tx_data = 8'h00;
    case (next_char)
      SEND_HI: tx_data = hex_ascii(src_byte[7:4]);
      SEND_LO: tx_data = src_bin ? src_byte : hex_ascii(src_byte[3:0]);
      SEND_CR: tx_data = ASCII_CR;
      SEND_LF: tx_data = ASCII_LF;
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data_q   <= 8'h00;
      bin_q    <= 1'b0;
      rd_ready <= 1'b1;
    end else if (state == IDLE) begin
      if (accept) begin
        state    <= next_char;
        data_q   <= rd_data;
        bin_q    <= bin_mode;
        rd_ready <= 1'b0;
      end
    end else if (tx_done) begin
      state    <= next_char;
      rd_ready <= (next_char == IDLE);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock   (clock),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .ser_out (ser_out)
  );

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb/tb_uart_resp_tx.sv - directed self-checking bench for uart_resp_tx at CLKS_PER_BIT=4
module tb_uart_resp_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data  = 8'h00;
  logic       bin_mode = 1'b0;
  logic       rd_ready;
  logic       ser_out;
  logic       busy;

  uart_resp_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset   (reset),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .bin_mode(bin_mode),
    .rd_ready(rd_ready),
    .ser_out (ser_out),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame decoder: samples mid-bit on falling edges; frames cut by reset are dropped, bad framing gets time -1.
  initial begin : monitor
    logic [7:0] ch;
    int         t0;
    logic       good;
    logic       rst_seen;
    forever begin
      @(negedge clock);
      if (reset && !ser_out) begin
        t0       = cyc;
        good     = 1'b1;
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        if (!reset) rst_seen = 1'b1;
        if (ser_out) good = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          ch[i] = ser_out;
          if (!reset) rst_seen = 1'b1;
        end
        repeat (CPB) @(negedge clock);
        if (!reset) rst_seen = 1'b1;
        if (!ser_out) good = 1'b0;
        if (!rst_seen) begin
          rx_q.push_back(ch);
          rx_t.push_back(good ? t0 : -1);
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clock);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic b, output int acc);
    @(negedge clock);
    rd_valid = 1'b1;
    rd_data  = d;
    bin_mode = b;
    @(negedge clock);
    acc      = cyc;
    rd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int t);
    int n = 0;
    while (!rd_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    t = rd_ready ? cyc : -100000;
  endtask

  task automatic check_resp(input string tag, input int base, input int first,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0]  e[4];
    logic [31:0] got_c;
    logic [31:0] got_t;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      got_c = (first + k < rx_q.size()) ? {24'h0, rx_q[first + k]} : 32'hFFFF_FFFF;
      got_t = (first + k < rx_t.size()) ? rx_t[first + k] : 32'hFFFF_FFFF;
      chk($sformatf("%s_char%0d", tag, k), got_c, {24'h0, e[k]});
      chk($sformatf("%s_start%0d", tag, k), got_t, base + k * FRAME);
    end
  endtask

  initial begin : main
    int         acc;
    int         acc2;
    int         done;
    int         errs;
    int         lows;
    logic [9:0] bin_pat;

    repeat (3) @(negedge clock);
    chk("rst_ser_out", ser_out, 1);
    chk("rst_rd_ready", rd_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // Text 0x3A -> "3A" CR LF
    rx_q.delete(); rx_t.delete();
    send(8'h3A, 1'b0, acc);
    chk("t3a_start_low", ser_out, 0);
    chk("t3a_busy", busy, 1);
    chk("t3a_not_ready", rd_ready, 0);
    wait_ready(done);
    chk("t3a_len", done - acc, 40 * CPB);
    chk("t3a_busy_end", busy, 0);
    chk("t3a_idle_high", ser_out, 1);
    chk("t3a_nchar", rx_q.size(), 4);
    check_resp("t3a", acc, 0, 8'h33, 8'h41, 8'h0D, 8'h0A);

    // Hex table ends
    rx_q.delete(); rx_t.delete();
    send(8'h00, 1'b0, acc);
    wait_ready(done);
    chk("t00_len", done - acc, 40 * CPB);
    check_resp("t00", acc, 0, 8'h30, 8'h30, 8'h0D, 8'h0A);
    rx_q.delete(); rx_t.delete();
    send(8'hFF, 1'b0, acc);
    wait_ready(done);
    chk("tff_len", done - acc, 40 * CPB);
    check_resp("tff", acc, 0, 8'h46, 8'h46, 8'h0D, 8'h0A);

    // Binary 0xA5: slots 0,1,0,1,0,0,1,0,1,1 (slot 0 is bit 0 of the pattern)
    rx_q.delete(); rx_t.delete();
    bin_pat = 10'b1101001010;
    errs    = 0;
    send(8'hA5, 1'b1, acc);
    for (int i = 0; i < FRAME; i++) begin
      if (ser_out !== bin_pat[i / CPB]) errs++;
      @(negedge clock);
    end
    chk("bin_bits", errs, 0);
    chk("bin_ready_at_40", rd_ready, 1);
    chk("bin_len", cyc - acc, FRAME);
    chk("bin_nchar", rx_q.size(), 1);
    chk("bin_char", (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF, 32'hA5);

    // rd_valid held: 0x12 then 0x34 taken only on the rd_ready re-assert cycle
    rx_q.delete(); rx_t.delete();
    @(negedge clock);
    rd_valid = 1'b1;
    rd_data  = 8'h12;
    bin_mode = 1'b0;
    @(negedge clock);
    acc     = cyc;
    rd_data = 8'h34;
    wait_ready(done);
    chk("b2b_len1", done - acc, 40 * CPB);
    @(negedge clock);
    acc2     = cyc;
    rd_valid = 1'b0;
    chk("b2b_accept2", acc2 - acc, 40 * CPB + 1);
    chk("b2b_busy2", busy, 1);
    wait_ready(done);
    chk("b2b_len2", done - acc2, 40 * CPB);
    chk("b2b_nchar", rx_q.size(), 8);
    check_resp("b2b_a", acc, 0, 8'h31, 8'h32, 8'h0D, 8'h0A);
    check_resp("b2b_b", acc2, 4, 8'h33, 8'h34, 8'h0D, 8'h0A);
    chk("b2b_gap", (rx_t.size() > 4) ? rx_t[4] - (rx_t[3] + FRAME) : -1, 1);

    // Reset during data bit 2 of 'A' (response offset 53), then 0x5C right after release
    rx_q.delete(); rx_t.delete();
    send(8'h3A, 1'b0, acc);
    repeat (FRAME + CPB + 2 * CPB + 1) @(negedge clock);
    chk("mid_pre_low", ser_out, 0);
    reset = 1'b0;
    #1;
    chk("mid_async_high", ser_out, 1);
    chk("mid_ready", rd_ready, 1);
    lows = 0;
    repeat (50) begin
      @(negedge clock);
      if (!ser_out) lows++;
    end
    chk("mid_hold_idle", lows, 0);
    chk("mid_nchar", rx_q.size(), 1);
    reset    = 1'b1;
    rd_valid = 1'b1;
    rd_data  = 8'h5C;
    bin_mode = 1'b0;
    @(negedge clock);
    acc      = cyc;
    rd_valid = 1'b0;
    chk("post_first_accept", ser_out, 0);
    chk("post_busy", busy, 1);
    wait_ready(done);
    chk("post_len", done - acc, 40 * CPB);
    chk("post_nchar", rx_q.size(), 5);
    check_resp("post_5c", acc, 1, 8'h35, 8'h43, 8'h0D, 8'h0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_resp_tx.md
UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit time; legal range 2..65535.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rd_valid  input  1  response byte available from the bus side.
REQ-005 rd_data  input  8  response byte (int_rd_data returned by the bus).
REQ-006 bin_mode  input  1  sampled with rd_data: 1 = raw binary byte, 0 = ASCII hex text line.
REQ-007 rd_ready  output  1  block can accept a response byte.
REQ-008 ser_out  output  1  UART serial output, 8N1, idle high.
REQ-009 busy  output  1  response transmission in progress.

Function
REQ-010 The block SHALL accept a byte only on a clock edge where rd_valid=1 and rd_ready=1, and SHALL capture rd_data and bin_mode on that edge.
REQ-011 rd_ready SHALL be 1 only in state IDLE; rd_valid while busy SHALL be ignored and nothing SHALL be queued.
REQ-012 The formatter FSM SHALL have states IDLE, SEND_HI, SEND_LO, SEND_CR, SEND_LF.
REQ-013 Text mode (bin_mode=0): IDLE->SEND_HI->SEND_LO->SEND_CR->SEND_LF->IDLE, one character per state.
REQ-014 Binary mode (bin_mode=1): IDLE->SEND_LO->IDLE; the character sent is the captured byte unchanged.
REQ-015 SEND_HI SHALL send the ASCII hex of rd_data[7:4], and SEND_LO the ASCII hex of rd_data[3:0]; use uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-016 SEND_CR SHALL send 0x0D, and SEND_LF SHALL send 0x0A.
REQ-017 Each character SHALL be one frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit is held exactly CLKS_PER_BIT cycles.
REQ-018 The serializer FSM SHALL have states S_IDLE, S_START, S_DATA, S_STOP, a 3-bit bit index, and a baud counter of width $clog2(CLKS_PER_BIT).
REQ-019 Latency: ser_out SHALL go low (start bit) in the first cycle after the accept edge.
REQ-020 Consecutive characters of one response SHALL be back-to-back: the next start bit begins in the cycle after the previous stop bit ends, with no idle gap.
REQ-021 A text response SHALL last exactly 40*CLKS_PER_BIT cycles; a binary response SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-022 rd_ready SHALL return to 1, and busy to 0, in the cycle after the final stop bit completes.
REQ-023 If rd_valid=1 in the cycle rd_ready returns high, the byte SHALL be accepted, giving a one-cycle idle-high gap between responses.
REQ-024 busy SHALL equal the inverse of rd_ready.
REQ-025 ser_out SHALL be 1 whenever the serializer is in S_IDLE and during S_STOP.
REQ-026 ser_out SHALL be driven from a register (glitch-free).

Reset
REQ-027 While reset=0: ser_out=1, rd_ready=1, busy=0, both FSMs idle, all counters and capture registers 0.
REQ-028 Reset asserted mid-frame SHALL force ser_out=1 immediately without waiting for a clock edge, and SHALL abandon the partial response.
REQ-029 After reset deasserts, the first accept SHALL be possible on the first rising clock edge.

Structure
REQ-030 The shared package uart2bus_pkg SHALL hold the ASCII constants (CR 0x0D, LF 0x0A, SPACE 0x20, TAB 0x09, 'R', 'r', 'W', 'w') and the nibble-to-ASCII-hex function; the command parser uses the same package.
REQ-031 Bit serialization SHALL be the sub-module uart_tx_byte, with a tx_start/tx_data/tx_done handshake; uart_resp_tx holds only the formatter FSM and the capture registers.

Verification (CLKS_PER_BIT=4)
REQ-032 Text 0x3A -> frames 0x33, 0x41, 0x0D, 0x0A; start bit the cycle after accept; rd_ready high again after 160 cycles.
REQ-033 Text 0x00 and 0xFF -> "00"+CR+LF and "FF"+CR+LF, covering both ends of the hex table.
REQ-034 Binary 0xA5 -> a single frame, ser_out bits 0,1,0,1,0,0,1,0,1,1 in 4-cycle slots; done after 40 cycles.
REQ-035 rd_valid held high with 0x12 then 0x34 -> 0x34 accepted only on the rd_ready re-assert cycle; the 0x12 line is intact; exactly 1 idle cycle between the two responses.
REQ-036 Reset pulse during the third data bit of 'A' -> ser_out=1 asynchronously, no further frames; after release, 0x5C is transmitted correctly as "5C"+CR+LF.
